// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared load/store definitions for the byte-addressable data memory.
// funct3 codes, pipeline stage record, byte-enable and load-extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic       write;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } stage_t;

    function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << addr_lo;
            F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory.
// master = requester side, slave = memory side.
interface dmem_lsu_if;

    logic        io_req_valid;
    logic        io_req_ready;
    logic        io_req_write;
    logic [2:0]  io_req_funct3;
    logic [31:0] io_req_addr;
    logic [31:0] io_req_wdata;
    logic        io_resp_ready;
    logic        io_resp_valid;
    logic [31:0] io_resp_rdata;
    logic        io_resp_err;
    logic        io_busy;

    modport master (
        output io_req_valid, io_req_write, io_req_funct3,
        output io_req_addr, io_req_wdata, io_resp_ready,
        input  io_req_ready, io_resp_valid, io_resp_rdata,
        input  io_resp_err, io_busy
    );

    modport slave (
        input  io_req_valid, io_req_write, io_req_funct3,
        input  io_req_addr, io_req_wdata, io_resp_ready,
        output io_req_ready, io_resp_valid, io_resp_rdata,
        output io_resp_err, io_busy
    );

endinterface

// File: rtl/dmem_lsu_ctrl_bank_be.sv
// DEPTH_WORDS x 32 memory with per-byte write enables and a registered read.
// Ports: clock, we/be/addr/wdata write side, re/rdata synchronous read side.
module dmem_bank_be #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read data holds when no request is taken, so a stalled
    // first stage keeps its word.
    always_comb begin
        rdata_d = re ? mem[addr] : rdata_q;
    end

    always_ff @(posedge clock) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// RV32I load/store front end over a byte-enabled data memory (MEM stage).
// Ports: clock, reset (sync, active-low), io = slave side of dmem_lsu_if.
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int READ_LAT        = 1,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input logic       clock,
    input logic       reset,
    dmem_lsu_if.slave io
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic        stall;
    logic        accept;
    logic        oor;
    logic        illegal;
    logic        misalign;
    logic        req_err;
    logic        is_half;
    logic        is_word;
    logic        busy;
    logic [1:0]  eff_lo;
    logic [31:0] wdata_rep;
    logic [31:0] bank_rdata;
    logic [2:0]  f3;
    logic [31:0] addr;
    stage_t      last;

    stage_t      stg_q [READ_LAT];
    stage_t      stg_d [READ_LAT];
    logic [31:0] word  [READ_LAT];

    assign f3   = io.io_req_funct3;
    assign addr = io.io_req_addr;
    assign last = stg_q[READ_LAT-1];

    assign stall           = last.valid && !io.io_resp_ready;
    assign io.io_req_ready = reset && !stall;
    assign accept          = io.io_req_valid && io.io_req_ready;

    assign is_half = (f3 == F3_H) || (f3 == F3_HU);
    assign is_word = (f3 == F3_W);
    assign oor     = addr[31:AW+2] != '0;
    assign illegal = (f3 == 3'd3) || (f3[2:1] == 2'b11)
                   || (io.io_req_write && f3[2]);
    assign misalign = ERR_ON_MISALIGN
                    && ((is_half && addr[0])
                    || (is_word && addr[1:0] != 2'b00));
    assign req_err = oor || illegal || misalign;

    // Natural alignment is always forced; with misalign errors
    // enabled the forced value is never used.
    always_comb begin
        eff_lo = addr[1:0];
        if (is_half) eff_lo[0] = 1'b0;
        if (is_word) eff_lo = 2'b00;
    end

    always_comb begin
        case (f3)
            F3_B:    wdata_rep = {4{io.io_req_wdata[7:0]}};
            F3_H:    wdata_rep = {2{io.io_req_wdata[15:0]}};
            default: wdata_rep = io.io_req_wdata;
        endcase
    end

    dmem_bank_be #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clock(clock),
        .we   (accept && io.io_req_write && !req_err),
        .be   (byte_en(f3, eff_lo)),
        .addr (addr[AW+1:2]),
        .wdata(wdata_rep),
        .re   (accept),
        .rdata(bank_rdata)
    );

    always_comb begin
        stg_d = stg_q;
        if (!stall) begin
            stg_d[0].valid   = accept;
            stg_d[0].err     = req_err;
            stg_d[0].write   = io.io_req_write;
            stg_d[0].funct3  = f3;
            stg_d[0].addr_lo = eff_lo;
            for (int i = 1; i < READ_LAT; i++) begin
                stg_d[i] = stg_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q <= stg_d;
        end
    end

    // Raw words for stages 2..READ_LAT; stage 1 word is the bank output.
    assign word[0] = bank_rdata;

    if (READ_LAT > 1) begin : g_dpipe
        logic [31:0] data_q [READ_LAT-1];
        logic [31:0] data_d [READ_LAT-1];

        always_comb begin
            for (int i = 0; i < READ_LAT-1; i++) begin
                data_d[i] = stall ? data_q[i] : word[i];
            end
        end

        always_ff @(posedge clock) begin
            data_q <= data_d;
        end

        for (genvar i = 1; i < READ_LAT; i++) begin : g_w
            assign word[i] = data_q[i-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < READ_LAT; i++) begin
            busy = busy | stg_q[i].valid;
        end
    end

    assign io.io_busy       = busy;
    assign io.io_resp_valid = last.valid;
    assign io.io_resp_err   = last.valid && last.err;
    assign io.io_resp_rdata = (last.valid && !last.err && !last.write)
        ? load_extend(last.funct3, last.addr_lo, word[READ_LAT-1])
        : 32'd0;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl: READ_LAT=1 and READ_LAT=3 instances.
// Table of single requests plus hand sequences for stall and reset cases.
module tb_dmem_lsu_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_lsu_if if1();
    dmem_lsu_if if3();

    dmem_lsu_ctrl #(
        .DEPTH_WORDS(1024), .READ_LAT(1), .ERR_ON_MISALIGN(1'b1)
    ) u1 (.clock(clk), .reset(rst_n), .io(if1));

    dmem_lsu_ctrl #(
        .DEPTH_WORDS(1024), .READ_LAT(3), .ERR_ON_MISALIGN(1'b1)
    ) u3 (.clock(clk), .reset(rst_n), .io(if3));

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    int got;
    logic [31:0] got_val [5];

    logic        v, e;
    logic [31:0] r;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic req1(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic ov, output logic oe,
                        output logic [31:0] orr);
        @(negedge clk);
        if1.io_req_valid  = 1'b1;
        if1.io_req_write  = wr;
        if1.io_req_funct3 = f3;
        if1.io_req_addr   = a;
        if1.io_req_wdata  = d;
        @(posedge clk);
        @(negedge clk);
        if1.io_req_valid = 1'b0;
        ov  = if1.io_resp_valid;
        oe  = if1.io_resp_err;
        orr = if1.io_resp_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, F3_W,  32'h80,   32'h11223344, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, F3_B,  32'h81,   32'h000000AB, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, F3_W,  32'h80,   32'h0, 1'b0, 32'h1122AB44};
        vecs[3]  = '{1'b0, F3_B,  32'h81,   32'h0, 1'b0, 32'hFFFFFFAB};
        vecs[4]  = '{1'b0, F3_BU, 32'h81,   32'h0, 1'b0, 32'h000000AB};
        vecs[5]  = '{1'b0, F3_HU, 32'h82,   32'h0, 1'b0, 32'h00001122};
        vecs[6]  = '{1'b0, F3_W,  32'h82,   32'h0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, F3_H,  32'h83,   32'h00005555, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, F3_W,  32'h80,   32'h0, 1'b0, 32'h1122AB44};
        vecs[9]  = '{1'b1, F3_BU, 32'h84,   32'h000000FF, 1'b1, 32'h0};
        vecs[10] = '{1'b1, F3_W,  32'h0,    32'hCAFEF00D, 1'b0, 32'h0};
        vecs[11] = '{1'b1, F3_W,  32'h1000, 32'h12345678, 1'b1, 32'h0};
        vecs[12] = '{1'b0, F3_W,  32'h0,    32'h0, 1'b0, 32'hCAFEF00D};
        vecs[13] = '{1'b0, F3_H,  32'h80,   32'h0, 1'b0, 32'hFFFFAB44};
        vecs[14] = '{1'b1, F3_H,  32'h86,   32'h1234BEEF, 1'b0, 32'h0};
        vecs[15] = '{1'b0, F3_HU, 32'h86,   32'h0, 1'b0, 32'h0000BEEF};
        vecs[16] = '{1'b0, 3'd3,  32'h80,   32'h0, 1'b1, 32'h0};
        vecs[17] = '{1'b0, 3'd7,  32'h80,   32'h0, 1'b1, 32'h0};
        vecs[18] = '{1'b1, F3_W,  32'hFFC,  32'h0BADF00D, 1'b0, 32'h0};
        vecs[19] = '{1'b0, F3_W,  32'hFFC,  32'h0, 1'b0, 32'h0BADF00D};
        vecs[20] = '{1'b0, F3_B,  32'h80,   32'h0, 1'b0, 32'h00000044};
        vecs[21] = '{1'b0, F3_W,  32'h1000, 32'h0, 1'b1, 32'h0};

        if1.io_req_valid  = 1'b1;
        if1.io_req_write  = 1'b1;
        if1.io_req_funct3 = F3_W;
        if1.io_req_addr   = 32'h200;
        if1.io_req_wdata  = 32'h00000BAD;
        if1.io_resp_ready = 1'b1;
        if3.io_req_valid  = 1'b0;
        if3.io_req_write  = 1'b0;
        if3.io_req_funct3 = F3_W;
        if3.io_req_addr   = 32'h0;
        if3.io_req_wdata  = 32'h0;
        if3.io_resp_ready = 1'b1;
        rst_n = 1'b0;

        // Reset held low three cycles with a request pending.
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", {31'd0, if1.io_req_ready}, 32'd0);
            chk("rst_resp_valid", {31'd0, if1.io_resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        if1.io_req_valid = 1'b0;
        #1;
        chk("rel_req_ready", {31'd0, if1.io_req_ready}, 32'd1);
        chk("rel_busy", {31'd0, if1.io_busy}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            req1(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 v, e, r);
            chk($sformatf("v%0d_valid", i), {31'd0, v}, 32'd1);
            chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_rdata", i), r, vecs[i].rdata);
        end

        // Store immediately followed by a load of the same word.
        @(negedge clk);
        if1.io_req_valid  = 1'b1;
        if1.io_req_write  = 1'b1;
        if1.io_req_funct3 = F3_W;
        if1.io_req_addr   = 32'h10;
        if1.io_req_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        chk("raw_sw_valid", {31'd0, if1.io_resp_valid}, 32'd1);
        chk("raw_sw_rdata", if1.io_resp_rdata, 32'd0);
        if1.io_req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if1.io_req_valid = 1'b0;
        chk("raw_lw_valid", {31'd0, if1.io_resp_valid}, 32'd1);
        chk("raw_lw_rdata", if1.io_resp_rdata, 32'hDEADBEEF);

        // A store presented during reset must not reach the array.
        req1(1'b1, F3_W, 32'h200, 32'h0000600D, v, e, r);
        chk("pre_rst_sw_valid", {31'd0, v}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        if1.io_req_valid  = 1'b1;
        if1.io_req_write  = 1'b1;
        if1.io_req_funct3 = F3_W;
        if1.io_req_addr   = 32'h200;
        if1.io_req_wdata  = 32'h00000BAD;
        repeat (3) begin
            @(negedge clk);
            chk("rst2_req_ready", {31'd0, if1.io_req_ready}, 32'd0);
            chk("rst2_resp_valid", {31'd0, if1.io_resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        if1.io_req_valid = 1'b0;
        req1(1'b0, F3_W, 32'h200, 32'h0, v, e, r);
        chk("rst2_lw_rdata", r, 32'h0000600D);

        // Preload five words for the READ_LAT=3 instance.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if3.io_req_valid  = 1'b1;
            if3.io_req_write  = 1'b1;
            if3.io_req_funct3 = F3_W;
            if3.io_req_addr   = 32'h100 + 32'(4 * k);
            if3.io_req_wdata  = 32'(k + 1);
            @(posedge clk);
        end
        @(negedge clk);
        if3.io_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("l3_drain_busy", {31'd0, if3.io_busy}, 32'd0);

        // Five back-to-back loads with a 4-cycle response stall.
        got = 0;
        fork
            begin
                int i = 0;
                int guard = 0;
                logic acc;
                while (i < 5 && guard < 60) begin
                    @(negedge clk);
                    if3.io_req_valid  = 1'b1;
                    if3.io_req_write  = 1'b0;
                    if3.io_req_funct3 = F3_W;
                    if3.io_req_addr   = 32'h100 + 32'(4 * i);
                    #2;
                    acc = if3.io_req_ready;
                    @(posedge clk);
                    if (acc) i++;
                    guard++;
                end
                @(negedge clk);
                if3.io_req_valid = 1'b0;
            end
            begin
                int stall_left = 0;
                bit started = 1'b0;
                for (int c = 0; c < 60 && got < 5; c++) begin
                    @(negedge clk);
                    if (if3.io_resp_valid && !started) begin
                        started = 1'b1;
                        stall_left = 4;
                    end
                    if (stall_left > 0) begin
                        if3.io_resp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        if3.io_resp_ready = 1'b1;
                    end
                    #1;
                    if (if3.io_resp_valid && !if3.io_resp_ready) begin
                        chk("bp_req_ready_stall",
                            {31'd0, if3.io_req_ready}, 32'd0);
                    end
                    if (if3.io_resp_valid && if3.io_resp_ready) begin
                        got_val[got] = if3.io_resp_rdata;
                        got++;
                    end
                end
            end
        join
        if3.io_resp_ready = 1'b1;
        chk("bp_resp_count", 32'(got), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got) chk($sformatf("bp_resp%0d", k), got_val[k], 32'(k + 1));
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_no_dup", {31'd0, if3.io_resp_valid}, 32'd0);
        end

        // Reset while two loads are in flight.
        @(negedge clk);
        if3.io_req_valid  = 1'b1;
        if3.io_req_write  = 1'b0;
        if3.io_req_funct3 = F3_W;
        if3.io_req_addr   = 32'h100;
        @(posedge clk);
        @(negedge clk);
        if3.io_req_addr = 32'h104;
        @(posedge clk);
        @(negedge clk);
        if3.io_req_valid = 1'b0;
        chk("mf_busy_before", {31'd0, if3.io_busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mf_busy_after", {31'd0, if3.io_busy}, 32'd0);
        repeat (6) begin
            chk("mf_no_resp", {31'd0, if3.io_resp_valid}, 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
